// File: rtl/key_dispatcher.sv
// key_dispatcher: latches HID keyboard reports and turns WASD / arrow keys
// into a per-player direction keycode plus frame-aligned step pulses.
module key_dispatcher_fsm #(
    parameter int REPEAT_DELAY = 20,
    parameter int REPEAT_RATE  = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       inGame,
    input  logic [7:0] dir,
    output logic [7:0] keycode,
    output logic       step
);

    typedef enum logic [1:0] {IDLE, ARMED, HOLD} state_t;

    state_t     state;
    logic [7:0] cur;
    logic [7:0] cnt;

    // Hop-on-press / hold-to-repeat state machine with registered outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            cur     <= 8'h00;
            cnt     <= 8'h00;
            keycode <= 8'h00;
            step    <= 1'b0;
        end else begin
            step <= 1'b0;
            if (!inGame) begin
                state   <= IDLE;
                keycode <= 8'h00;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (dir != 8'h00) begin
                            cur     <= dir;
                            keycode <= dir;
                            state   <= ARMED;
                        end
                    end
                    ARMED: begin
                        // a tap shorter than a frame keeps its pending step
                        if (dir != 8'h00 && dir != cur) begin
                            cur     <= dir;
                            keycode <= dir;
                        end
                        if (frame_tick) begin
                            step  <= 1'b1;
                            cnt   <= 8'(REPEAT_DELAY - 1);
                            state <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (dir == 8'h00) begin
                            state   <= IDLE;
                            keycode <= 8'h00;
                        end else if (dir != cur) begin
                            cur     <= dir;
                            keycode <= dir;
                            state   <= ARMED;
                        end else if (frame_tick) begin
                            if (cnt == 8'h00) begin
                                step <= 1'b1;
                                cnt  <= 8'(REPEAT_RATE - 1);
                            end else begin
                                cnt <= cnt - 8'd1;
                            end
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        keycode <= 8'h00;
                    end
                endcase
            end
        end
    end

endmodule

module key_dispatcher #(
    parameter int REPEAT_DELAY = 20,
    parameter int REPEAT_RATE  = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_tick,
    input  logic        inGame,
    input  logic        report_valid,
    input  logic [47:0] report_keys,
    output logic [7:0]  p1_keycode,
    output logic        p1_step,
    output logic [7:0]  p2_keycode,
    output logic        p2_step
);

    logic [47:0] report_q;
    logic [7:0]  dir1_d;
    logic [7:0]  dir2_d;
    logic [7:0]  dir1_q;
    logic [7:0]  dir2_q;

    function automatic logic has_key(input logic [47:0] r,
                                     input logic [7:0]  k);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (r[i*8 +: 8] == k) hit = 1'b1;
        end
        return hit;
    endfunction

    // Capture the host report; ErrorRollOver reports read as no keys.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            report_q <= 48'h0;
        end else if (report_valid) begin
            if (has_key(report_keys, 8'h01)) report_q <= 48'h0;
            else                             report_q <= report_keys;
        end
    end

    // Priority decode of one direction per player.
    always_comb begin
        dir1_d = 8'h00;
        if      (has_key(report_q, 8'h1A)) dir1_d = 8'h1A;
        else if (has_key(report_q, 8'h16)) dir1_d = 8'h16;
        else if (has_key(report_q, 8'h04)) dir1_d = 8'h04;
        else if (has_key(report_q, 8'h07)) dir1_d = 8'h07;
        dir2_d = 8'h00;
        if      (has_key(report_q, 8'h52)) dir2_d = 8'h52;
        else if (has_key(report_q, 8'h51)) dir2_d = 8'h51;
        else if (has_key(report_q, 8'h50)) dir2_d = 8'h50;
        else if (has_key(report_q, 8'h4F)) dir2_d = 8'h4F;
    end

    // Register the decoded directions.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            dir1_q <= 8'h00;
            dir2_q <= 8'h00;
        end else begin
            dir1_q <= dir1_d;
            dir2_q <= dir2_d;
        end
    end

    key_dispatcher_fsm #(
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE)
    ) u_p1 (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_tick(frame_tick),
        .inGame    (inGame),
        .dir       (dir1_q),
        .keycode   (p1_keycode),
        .step      (p1_step)
    );

    key_dispatcher_fsm #(
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE)
    ) u_p2 (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_tick(frame_tick),
        .inGame    (inGame),
        .dir       (dir2_q),
        .keycode   (p2_keycode),
        .step      (p2_step)
    );

endmodule

// File: tb/tb_key_dispatcher.sv
// tb_key_dispatcher: directed and random stimulus checked every cycle
// against a frame-counting reference model of the dispatcher.
module tb_key_dispatcher;

    localparam int RD = 20;
    localparam int RR = 8;

    logic        Clk;
    logic        Reset;
    logic        frame_tick;
    logic        inGame;
    logic        report_valid;
    logic [47:0] report_keys;
    logic [7:0]  p1_keycode;
    logic        p1_step;
    logic [7:0]  p2_keycode;
    logic        p2_step;

    key_dispatcher #(.REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_tick  (frame_tick),
        .inGame      (inGame),
        .report_valid(report_valid),
        .report_keys (report_keys),
        .p1_keycode  (p1_keycode),
        .p1_step     (p1_step),
        .p2_keycode  (p2_keycode),
        .p2_step     (p2_step)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_assert = 0;
    int n_fail   = 0;
    int n1 = 0;
    int n2 = 0;

    // reference model: report contents, decoded direction, per-player hold
    logic [47:0] m_rep = 48'h0;
    logic [7:0]  m_dir [2] = '{8'h00, 8'h00};
    bit          m_act [2] = '{0, 0};
    bit          m_pend[2] = '{0, 0};
    logic [7:0]  m_cur [2] = '{8'h00, 8'h00};
    int          m_held[2] = '{0, 0};
    int          m_nst [2] = '{0, 0};
    logic [7:0]  e_key [2] = '{8'h00, 8'h00};
    bit          e_step[2] = '{0, 0};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_dir(input logic [47:0] r,
                                           input int p);
        logic [7:0] pri[4];
        if (p == 0) pri = '{8'h1A, 8'h16, 8'h04, 8'h07};
        else        pri = '{8'h52, 8'h51, 8'h50, 8'h4F};
        for (int k = 0; k < 4; k++)
            for (int s = 0; s < 6; s++)
                if (r[s*8 +: 8] == pri[k]) return pri[k];
        return 8'h00;
    endfunction

    task automatic model_update();
        logic [47:0] nrep;
        logic [7:0]  ndir[2];
        logic [7:0]  d;
        int          lim;
        if (Reset) begin
            m_rep = 48'h0;
            for (int p = 0; p < 2; p++) begin
                m_dir[p] = 0; m_act[p] = 0; m_pend[p] = 0;
                m_cur[p] = 0; m_held[p] = 0; m_nst[p] = 0;
                e_key[p] = 0; e_step[p] = 0;
            end
            return;
        end
        nrep = m_rep;
        if (report_valid) begin
            nrep = report_keys;
            for (int s = 0; s < 6; s++)
                if (report_keys[s*8 +: 8] == 8'h01) nrep = 48'h0;
        end
        for (int p = 0; p < 2; p++) begin
            ndir[p]   = ref_dir(m_rep, p);
            d         = m_dir[p];
            e_step[p] = 0;
            if (!inGame) begin
                m_act[p] = 0; m_pend[p] = 0;
            end else if (!m_act[p]) begin
                if (d != 0) begin
                    m_act[p] = 1; m_pend[p] = 1; m_cur[p] = d;
                end
            end else if (m_pend[p]) begin
                if (d != 0 && d != m_cur[p]) m_cur[p] = d;
                if (frame_tick) begin
                    e_step[p] = 1; m_pend[p] = 0;
                    m_held[p] = 0; m_nst[p] = 1;
                end
            end else begin
                if (d == 0) m_act[p] = 0;
                else if (d != m_cur[p]) begin
                    m_cur[p] = d; m_pend[p] = 1;
                end else if (frame_tick) begin
                    m_held[p]++;
                    lim = (m_nst[p] == 1) ? RD : RR;
                    if (m_held[p] == lim) begin
                        e_step[p] = 1; m_held[p] = 0; m_nst[p]++;
                    end
                end
            end
        end
        m_rep = nrep;
        m_dir = ndir;
        for (int p = 0; p < 2; p++) e_key[p] = m_act[p] ? m_cur[p] : 8'h00;
    endtask

    task automatic step_clk();
        @(posedge Clk);
        model_update();
        #1;
        check("p1_keycode", {24'h0, p1_keycode}, {24'h0, e_key[0]});
        check("p1_step", {31'h0, p1_step}, {31'h0, e_step[0]});
        check("p2_keycode", {24'h0, p2_keycode}, {24'h0, e_key[1]});
        check("p2_step", {31'h0, p2_step}, {31'h0, e_step[1]});
        if (p1_step === 1'b1) n1++;
        if (p2_step === 1'b1) n2++;
    endtask

    task automatic send(input logic [47:0] k);
        report_keys  = k;
        report_valid = 1'b1;
        step_clk();
        report_valid = 1'b0;
    endtask

    task automatic ftick();
        frame_tick = 1'b1;
        step_clk();
        frame_tick = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step_clk();
    endtask

    function automatic logic [47:0] rand_report();
        logic [7:0]  pool[10];
        logic [47:0] r;
        pool = '{8'h00, 8'h1A, 8'h16, 8'h04, 8'h07,
                 8'h52, 8'h51, 8'h50, 8'h4F, 8'h2C};
        for (int s = 0; s < 6; s++) begin
            if ($urandom_range(0, 39) == 0) r[s*8 +: 8] = 8'h01;
            else r[s*8 +: 8] = pool[$urandom_range(0, 9)];
        end
        return r;
    endfunction

    int hits[$];
    int exp_hits[6] = '{1, 21, 29, 37, 45, 53};

    initial begin
        Reset = 1'b1; frame_tick = 1'b0; inGame = 1'b0;
        report_valid = 1'b0; report_keys = 48'h0;
        idle(2);
        Reset = 1'b0;
        inGame = 1'b1;
        idle(2);

        // tap: 0x1A for 3 cycles then released before the tick
        n1 = 0; n2 = 0;
        send(48'h1A);
        idle(2);
        send(48'h00);
        idle(1);
        check("tap_key", {24'h0, p1_keycode}, 32'h1A);
        ftick();
        check("tap_step_now", {31'h0, p1_step}, 32'h1);
        idle(3);
        ftick();
        idle(2);
        check("tap_p1_steps", n1, 1);
        check("tap_p2_steps", n2, 0);
        check("tap_idle_key", {24'h0, p1_keycode}, 32'h0);

        // hold 0x4F for 60 ticks
        send(48'h4F);
        idle(2);
        for (int i = 1; i <= 60; i++) begin
            ftick();
            if (p2_step === 1'b1) hits.push_back(i);
            check("hold_key", {24'h0, p2_keycode}, 32'h4F);
            idle(3);
        end
        check("hold_count", hits.size(), 6);
        for (int i = 0; i < 6 && i < hits.size(); i++)
            check("hold_tick", hits[i], exp_hits[i]);
        send(48'h00);
        idle(3);

        // priority and independence
        send({24'h0, 8'h52, 8'h07, 8'h04});
        idle(2);
        check("pri_p1", {24'h0, p1_keycode}, 32'h04);
        check("pri_p2", {24'h0, p2_keycode}, 32'h52);
        ftick();
        check("pri_both", {30'h0, p1_step, p2_step}, 32'h3);
        idle(2);
        send({16'h0, 8'h1A, 8'h52, 8'h07, 8'h04});
        idle(2);
        ftick();
        check("pri_sw_step", {31'h0, p1_step}, 32'h1);
        check("pri_sw_key", {24'h0, p1_keycode}, 32'h1A);
        check("pri_p2_quiet", {31'h0, p2_step}, 32'h0);
        send(48'h00);
        idle(3);

        // direction change on the tick cycle while holding
        send(48'h16);
        idle(2);
        ftick();
        idle(2);
        send(48'h07);
        idle(1);
        ftick();
        check("chg_nostep", {31'h0, p1_step}, 32'h0);
        check("chg_key", {24'h0, p1_keycode}, 32'h07);
        idle(2);
        ftick();
        check("chg_step", {31'h0, p1_step}, 32'h1);
        for (int i = 0; i < 19; i++) begin ftick(); idle(1); end
        check("chg_quiet", {31'h0, p1_step}, 32'h0);
        ftick();
        check("chg_repeat", {31'h0, p1_step}, 32'h1);
        send(48'h00);
        idle(3);

        // rollover report
        send({16'h0, 8'h01, 8'h52, 8'h00, 8'h1A});
        idle(2);
        ftick();
        check("roll_keys", {16'h0, p1_keycode, p2_keycode}, 32'h0);
        check("roll_steps", {30'h0, p1_step, p2_step}, 32'h0);

        // inGame dropped while armed, then restored with key held
        send(48'h1A);
        idle(2);
        inGame = 1'b0;
        ftick();
        check("ig_drop", {23'h0, p1_step, p1_keycode}, 32'h0);
        idle(2);
        inGame = 1'b1;
        ftick();
        check("ig_nostep", {31'h0, p1_step}, 32'h0);
        ftick();
        check("ig_step", {31'h0, p1_step}, 32'h1);
        send(48'h00);
        idle(3);

        // reset in HOLD with the counter at 5
        send(48'h1A);
        idle(2);
        ftick();
        for (int i = 0; i < 14; i++) begin ftick(); idle(1); end
        Reset = 1'b1;
        step_clk();
        Reset = 1'b0;
        check("rst_outs", {14'h0, p1_step, p2_step, p1_keycode, p2_keycode},
              32'h0);
        send(48'h1A);
        idle(2);
        ftick();
        check("rst_resume", {31'h0, p1_step}, 32'h1);

        // random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            Reset        = ($urandom_range(0, 199) == 0);
            inGame       = ($urandom_range(0, 39) != 0);
            report_valid = ($urandom_range(0, 5) == 0);
            report_keys  = rand_report();
            frame_tick   = ($urandom_range(0, 2) == 0);
            step_clk();
        end
        Reset = 1'b0; report_valid = 1'b0; frame_tick = 1'b0;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
